memory_sdp_pipe: RTL
====================

// Module: memory_sdp_pipe
// PURPOSE
// - Parametrised simple-dual-port RAM: synchronous write port, registered (pipelined) read port with valid strobe.
// - Built-in clear engine fills the array with INIT_VALUE after every reset; ports blocked while clearing.
// - Successor to the 8x256 async-read memory; serves as line buffer / scratchpad behind datapath blocks.
// PARAMETERS
// - DATA_WIDTH  8     width of data_in/data_out
// - ADDR_WIDTH  8     width of wr_addr/rd_add
// - DEPTH       256   number of words, 1..2**ADDR_WIDTH; addresses >= DEPTH are out of range
// - RD_LATENCY  1     read pipeline depth, legal values 1 or 2
// - INIT_VALUE  0     word written to every location by the clear engine
// PORTS
// - clk           in   1           single clock, all state on rising edge
// - rst           in   1           asynchronous, active-high reset
// - data_in       in   DATA_WIDTH  write data
// - write_enable  in   1           write strobe, sampled at posedge clk
// - wr_addr       in   ADDR_WIDTH  write address
// - rd_en         in   1           read request, sampled at posedge clk
// - rd_add        in   ADDR_WIDTH  read address
// - data_out      out  DATA_WIDTH  read data, qualified by rd_valid
// - rd_valid      out  1           data_out holds result of a request issued RD_LATENCY cycles earlier
// - init_busy     out  1           clear engine active; all requests rejected
// - wr_err        out  1           1-cycle pulse: write rejected (busy or out of range)
// - rd_err        out  1           1-cycle pulse: read rejected (busy or out of range)
// BEHAVIOUR
// - Reset values: data_out=0, rd_valid=0, init_busy=1, wr_err=0, rd_err=0; FSM=CLEAR, clear counter=0.
// - Array contents are not reset; the clear engine initialises them.
// - FSM CLEAR: each cycle after rst deasserts, writes INIT_VALUE to mem[cnt], cnt++; at cnt==DEPTH-1 -> READY.
// - CLEAR takes exactly DEPTH cycles; init_busy falls on the edge that writes the last location.
// - FSM READY: stays until rst; no other exits.
// - Write: in READY, write_enable=1 and wr_addr<DEPTH -> mem[wr_addr]<=data_in at that edge.
// - Read: in READY, rd_en=1, rd_add<DEPTH at edge N -> data_out valid, rd_valid=1 at edge N+RD_LATENCY.
// - Reads fully pipelined: one request per cycle, results returned in order, no stalls.
// - rd_valid low -> data_out holds its last valid value (no glitch to 0).
// - Rejected write (CLEAR or addr>=DEPTH): array unchanged, wr_err=1 for the following cycle.
// - Rejected read (CLEAR or addr>=DEPTH): no rd_valid, rd_err=1 for the following cycle.
// - Simultaneous rejected write and rejected read: both wr_err and rd_err pulse.
// - Write and read to different addresses, same edge: independent, both succeed.
// - Same-address read during write: see CONFIGURATION.
// - rst mid-operation: read pipeline flushed (rd_valid=0 at once), in-flight reads lost, CLEAR restarts at 0.
// - DEPTH < 2**ADDR_WIDTH: out-of-range addresses never alias into the array.
// CONFIGURATION
// - Macro MEM_WR_BYPASS_EN.
// - Defined: same-edge read+write to one address returns new data_in (write-first forwarding through the pipeline).
// - Undefined: same-edge read+write returns the old stored word (read-first); new word is visible to later reads.
// - All other behaviour is identical in both builds.
// TESTING  (clk period 10 ns; DATA_WIDTH=8, ADDR_WIDTH=8, DEPTH=256 unless stated)
// - Release rst; count cycles -> init_busy high for exactly 256 cycles; then reads of 0x00, 0x7F, 0xFF return INIT_VALUE.
// - Write 24,25,26,27 to addr 10..13, then read 10..13 back-to-back -> rd_valid 4 consecutive cycles with 24,25,26,27 after RD_LATENCY (check both 1 and 2).
// - Write 0x55 to addr 20 while init_busy=1 -> wr_err pulse; after clear, read addr 20 -> INIT_VALUE.
// - DEPTH=200: write 0xAA to addr 210 -> wr_err; read addr 210 -> rd_err, no rd_valid; addr 10 unchanged.
// - mem[30]=0x11, same edge write 0x22 + read addr 30 -> 0x11 without MEM_WR_BYPASS_EN, 0x22 with it; next read -> 0x22.
// - Assert rst with 2 reads in flight -> rd_valid=0 immediately, no late valid; init_busy=1; clear reruns full 256 cycles.

Source files
------------

// File: rtl/memory_sdp_pipe.sv
// memory_sdp_pipe
//   Simple-dual-port RAM with a synchronous write port and a registered,
//   fully pipelined read port (RD_LATENCY of 1 or 2) qualified by rd_valid.
//   After every reset a clear engine writes INIT_VALUE to all DEPTH words.
//   While it runs, init_busy is high and every request is rejected.
//
// Parameters
//   DATA_WIDTH  word width
//   ADDR_WIDTH  address width; addresses >= DEPTH are out of range
//   DEPTH       number of words, 1..2**ADDR_WIDTH
//   RD_LATENCY  read pipeline depth, 1 or 2
//   INIT_VALUE  word written by the clear engine
//
// Ports
//   clk, rst                 single rising-edge clock, async active-high reset
//   data_in, write_enable,   write port; accepted only in READY and in range
//   wr_addr
//   rd_en, rd_add            read request; accepted only in READY and in range
//   data_out, rd_valid       read result RD_LATENCY edges after the request;
//                            data_out holds its value while rd_valid is low
//   init_busy                clear engine active
//   wr_err, rd_err           one-cycle pulses for rejected write / read
//
// Build option
//   MEM_WR_BYPASS_EN  defined: a same-edge read of the address being written
//                     returns the new data_in (write-first).
//                     undefined: that read returns the old word (read-first).

module memory_sdp_pipe #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DEPTH      = 256,
  parameter int unsigned           RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_add,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  init_busy,
  output logic                  wr_err,
  output logic                  rd_err
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr_in_range;
  logic                    rd_in_range;
  logic                    wr_ok;
  logic                    rd_ok;
  logic                    clr_we;
  logic [DATA_WIDTH-1:0]   rd_word;

  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
    rd_in_range = ({1'b0, rd_add} < DEPTH_EXT);
    wr_ok       = (state == READY) && write_enable && wr_in_range;
    rd_ok       = (state == READY) && rd_en && rd_in_range;
    // The clear engine only writes once reset has been released.
    clr_we      = (state == CLEAR) && !rst;
  end

  always_comb begin
    rd_word = mem[rd_add];
`ifdef MEM_WR_BYPASS_EN
    if (wr_ok && (wr_addr == rd_add)) begin
      rd_word = data_in;
    end
`endif
  end

  // Storage has no reset; contents come from the clear engine.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= INIT_VALUE;
    end else if (wr_ok) begin
      mem[wr_addr] <= data_in;
    end
  end

  // Control FSM and error strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      init_busy <= 1'b1;
      wr_err    <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      wr_err <= write_enable && !wr_ok;
      rd_err <= rd_en && !rd_ok;
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            state     <= READY;
            init_busy <= 1'b0;
          end
        end
        READY: begin
          state <= READY;
        end
        default: begin
          state     <= CLEAR;
          clr_cnt   <= '0;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  // Read pipeline. The array read is captured on the request edge so that
  // read-first ordering falls out of non-blocking write semantics.
  if (RD_LATENCY == 2) begin : g_lat2
    logic                  p1_valid;
    logic [DATA_WIDTH-1:0] p1_data;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        p1_valid <= 1'b0;
        p1_data  <= '0;
        rd_valid <= 1'b0;
        data_out <= '0;
      end else begin
        p1_valid <= rd_ok;
        if (rd_ok) begin
          p1_data <= rd_word;
        end
        rd_valid <= p1_valid;
        if (p1_valid) begin
          data_out <= p1_data;
        end
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_valid <= 1'b0;
        data_out <= '0;
      end else begin
        rd_valid <= rd_ok;
        if (rd_ok) begin
          data_out <= rd_word;
        end
      end
    end
  end

endmodule
